snake_arena_map: RTL and testbench
==================================

SNAKE_ARENA_MAP -- requirements
Module: snake_arena_map

Interface
REQ-001 SHALL have parameter GRID_W, default 40, grid columns.
REQ-002 SHALL have parameter GRID_H, default 30, grid rows.
REQ-003 SHALL have parameters XW, default 6, and YW, default 5: coordinate widths, set by instantiator, with GRID_W <= 2^XW and GRID_H <= 2^YW.
REQ-004 SHALL have parameter NSNAKE, default 2, legal 1..4: number of independent snakes. Cell owner code is 3 bits: 0 = empty, k+1 = snake k.
REQ-005 SHALL have these ports, each as name, direction, width, meaning:
- clk, in, 1: single clock, all state on rising edge.
- reset, in, 1: asynchronous, active-high.
- clear, in, 1: start a full-map clear sweep.
- tick, in, 1: game step strobe.
- alive, in, NSNAKE: snake k takes part in this tick.
- eat, in, NSNAKE: snake k grows and does not pop its tail.
- head_xy, in, NSNAKE*(XW+YW): current head {x,y} per snake; it becomes body on tick.
- tail_xy, in, NSNAKE*(XW+YW): tail {x,y} per snake; cleared on tick when eat=0.
- next_xy, in, NSNAKE*(XW+YW): next head {x,y} per snake, used for collision.
- q_x, in, XW: query column.
- q_y, in, YW: query row.
- q_owner, out, 3: combinational owner code at (q_x,q_y).
- body_on, out, 1: q_owner != 0.
- hit_self, out, NSNAKE: registered collision flag per snake.
- hit_other, out, NSNAKE: registered collision flag per snake.
- hit_head, out, NSNAKE: registered collision flag per snake.
- hit_valid, out, 1: one-cycle pulse qualifying the hit_* outputs.
- busy, out, 1: clear sweep in progress.
- tick_drop, out, 1: sticky flag, set when a tick is ignored.
- snake_len, out, NSNAKE*12: per-snake occupied-cell count (see REQ-020).

Function
REQ-006 SHALL store one 3-bit owner code per cell. Packed xy fields are ordered snake 0 in the LSBs, x above y.
REQ-007 SHALL run a two-state FSM:
- CLEAR: zeros one row per cycle, row counter 0 to GRID_H-1, busy=1, then goes to IDLE after the cycle clearing row GRID_H-1.
- IDLE: busy=0.
REQ-008 SHALL enter CLEAR at row 0 on clear=1 in any state. A clear during CLEAR restarts the sweep at row 0.
REQ-009 SHALL ignore tick while in CLEAR or while clear=1, and SHALL set tick_drop. tick_drop clears only on reset or on a clear accepted in IDLE.
REQ-010 SHALL evaluate collisions in IDLE on tick for every snake k with alive[k]=1, using map contents before this tick's update. Let o = owner at next_k. The cell counts as vacating if some alive snake j has eat[j]=0 and tail_j == next_k.
REQ-011 SHALL compute the three flags for each such snake k as follows:
- hit_self[k] = (o == k+1 and not vacating) or next_k == head_k.
- hit_other[k] = (o != 0, o != k+1, not vacating) or next_k == head_j for any alive j != k.
- hit_head[k] = next_k == next_j for any alive j != k.
REQ-012 SHALL register the hit_* outputs and assert hit_valid exactly one cycle after an accepted tick. hit_* hold their value until the next accepted tick. Snakes with alive=0 report 0.
REQ-013 SHALL update the map on the accepted tick edge, in this order:
- first, clear tail_k for each alive k with eat[k]=0;
- then write k+1 at head_k for each alive k, overriding any clear;
- on equal heads, the lowest index wins.
REQ-014 SHALL make the updates visible on q_owner in the cycle after the tick edge.
REQ-015 SHALL ignore coordinates outside the grid: no write, owner reads as 0, and no hit from the occupancy term.
REQ-016 SHALL NOT infer multicycle paths. Collision logic is single-cycle combinational into the hit registers.

Reset
REQ-017 SHALL, on reset assertion, asynchronously force state CLEAR at row 0 and set busy=1. hit_*=0, hit_valid=0, tick_drop=0, snake_len=0.
REQ-018 SHALL complete the post-reset sweep in GRID_H cycles after reset deasserts; busy falls on the following cycle.
REQ-019 SHALL treat reset mid-sweep or mid-tick as a full restart; no partial update may survive.

Configuration
REQ-020 SHALL compile the length counters only with macro SNAKE_ARENA_LEN_EN:
- defined: snake_len[k] increments on each accepted write of head_k to a cell not already owned by k+1, and decrements on each effective tail clear of a cell owned by k+1; it is zeroed by a clear sweep and saturates at 0 and 4095.
- undefined: snake_len is tied to 0 and no counter logic exists.

Verification (GRID_W=8, GRID_H=6, XW=3, YW=3, NSNAKE=2)
REQ-021 SHALL test reset: release reset, then busy=1 for 6 cycles, then 0; all 48 cells have q_owner=0; a tick sent while busy sets tick_drop=1 and leaves the map unchanged.
REQ-022 SHALL test growth and pop for snake 0: ticks eat=1 with head (2,2) then (3,2), then eat=0 with head (4,2) and tail (2,2). Result: cells (3,2) and (4,2) hold owner 1, (2,2) holds 0, no hits, snake_len[0]=2 with the macro defined.
REQ-023 SHALL test the tail exception: snake 0 has next=(3,2) equal to its own popping tail (3,2) -> hit_self[0]=0. Repeat with eat=1 -> hit_self[0]=1 on hit_valid.
REQ-024 SHALL test snake-on-snake: snake 1 moves to next=(4,2), a non-vacating cell owned by snake 0 -> hit_other[1]=1, hit_self[1]=0.
REQ-025 SHALL test head-on: snakes 0 and 1 both have next=(5,5) -> hit_head=2'b11. A clear issued one cycle later -> busy=1 for 6 cycles and tick_drop cleared.

Source files
------------

// File: rtl/snake_arena_map.sv
// snake_arena_map
// Owner map for a multi-snake arena. Each grid cell holds a 3-bit owner code:
// 0 = empty, k+1 = snake k. On an accepted tick the map evaluates collisions
// for every alive snake against the pre-tick contents, then pops tails and
// writes heads. A clear (or reset) sweeps the map one row per cycle.
//
// Optional feature: define SNAKE_ARENA_LEN_EN to build the per-snake
// occupied-cell counters on snake_len; otherwise snake_len is tied to 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clear                 start (or restart) a full-map clear sweep
//   tick                  game step strobe
//   alive, eat            per-snake participation / growth flags
//   head_xy, tail_xy,     packed {x,y} per snake, snake 0 in the LSBs
//   next_xy
//   q_x, q_y              query coordinate
//   q_owner, body_on      combinational owner at the query cell
//   hit_self, hit_other,  registered per-snake collision flags
//   hit_head
//   hit_valid             one-cycle pulse after an accepted tick
//   busy                  clear sweep in progress
//   tick_drop             sticky: a tick was ignored
//   snake_len             per-snake 12-bit cell counts (optional)

module snake_arena_map #(
   parameter int GRID_W = 40,
   parameter int GRID_H = 30,
   parameter int XW     = 6,
   parameter int YW     = 5,
   parameter int NSNAKE = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      tick,
   input  logic [NSNAKE-1:0]         alive,
   input  logic [NSNAKE-1:0]         eat,
   input  logic [NSNAKE*(XW+YW)-1:0] head_xy,
   input  logic [NSNAKE*(XW+YW)-1:0] tail_xy,
   input  logic [NSNAKE*(XW+YW)-1:0] next_xy,
   input  logic [XW-1:0]             q_x,
   input  logic [YW-1:0]             q_y,
   output logic [2:0]                q_owner,
   output logic                      body_on,
   output logic [NSNAKE-1:0]         hit_self,
   output logic [NSNAKE-1:0]         hit_other,
   output logic [NSNAKE-1:0]         hit_head,
   output logic                      hit_valid,
   output logic                      busy,
   output logic                      tick_drop,
   output logic [NSNAKE*12-1:0]      snake_len
);

   localparam int CW = XW + YW;

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t          state;
   logic [YW-1:0]   row;
   logic [2:0]      cells [GRID_H][GRID_W];

   logic [CW-1:0]   hd [NSNAKE];
   logic [CW-1:0]   tl [NSNAKE];
   logic [CW-1:0]   nt [NSNAKE];
   logic [XW-1:0]   hx [NSNAKE];
   logic [XW-1:0]   tx [NSNAKE];
   logic [XW-1:0]   nx [NSNAKE];
   logic [YW-1:0]   hy [NSNAKE];
   logic [YW-1:0]   ty [NSNAKE];
   logic [YW-1:0]   ny [NSNAKE];
   logic            h_in [NSNAKE];
   logic            t_in [NSNAKE];
   logic [2:0]      n_own [NSNAKE];

   logic [NSNAKE-1:0] hs_c, ho_c, hh_c;
   logic              tick_acc, tick_ign;

   // Coordinates outside the grid never write, read as empty and never hit.
   function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (int'(x) < GRID_W) && (int'(y) < GRID_H);
   endfunction

   assign tick_acc = tick && (state == S_IDLE) && !clear;
   assign tick_ign = tick && ((state == S_CLEAR) || clear);

   // Split the packed buses into per-snake x/y and look up pre-tick owners.
   for (genvar g = 0; g < NSNAKE; g++) begin : g_unpack
      assign hd[g]    = head_xy[g*CW +: CW];
      assign tl[g]    = tail_xy[g*CW +: CW];
      assign nt[g]    = next_xy[g*CW +: CW];
      assign hx[g]    = hd[g][CW-1 -: XW];
      assign hy[g]    = hd[g][YW-1:0];
      assign tx[g]    = tl[g][CW-1 -: XW];
      assign ty[g]    = tl[g][YW-1:0];
      assign nx[g]    = nt[g][CW-1 -: XW];
      assign ny[g]    = nt[g][YW-1:0];
      assign h_in[g]  = in_grid(hx[g], hy[g]);
      assign t_in[g]  = in_grid(tx[g], ty[g]);
      assign n_own[g] = in_grid(nx[g], ny[g]) ? cells[ny[g]][nx[g]] : 3'd0;
   end

   assign q_owner = in_grid(q_x, q_y) ? cells[q_y][q_x] : 3'd0;
   assign body_on = (q_owner != 3'd0);

   // Collision terms for every snake, all from the map as it stands before
   // this tick. A cell whose owner is popping its tail this tick is treated
   // as free for the occupancy terms only; head/next comparisons still apply.
   always_comb begin
      logic vac;
      hs_c = '0;
      ho_c = '0;
      hh_c = '0;
      vac  = 1'b0;
      for (int k = 0; k < NSNAKE; k++) begin
         vac = 1'b0;
         for (int j = 0; j < NSNAKE; j++) begin
            if (alive[j] && !eat[j] && (tl[j] == nt[k]))
               vac = 1'b1;
         end
         if (alive[k]) begin
            hs_c[k] = ((n_own[k] == 3'(k + 1)) && !vac) || (nt[k] == hd[k]);
            ho_c[k] = (n_own[k] != 3'd0) && (n_own[k] != 3'(k + 1)) && !vac;
            for (int j = 0; j < NSNAKE; j++) begin
               if ((j != k) && alive[j]) begin
                  if (nt[k] == hd[j]) ho_c[k] = 1'b1;
                  if (nt[k] == nt[j]) hh_c[k] = 1'b1;
               end
            end
         end
      end
   end

   // Sweep FSM plus the registered status and collision outputs. A clear in
   // any state restarts the sweep at row 0; the last row's cycle hands over
   // to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_CLEAR;
         row       <= '0;
         busy      <= 1'b1;
         tick_drop <= 1'b0;
         hit_self  <= '0;
         hit_other <= '0;
         hit_head  <= '0;
         hit_valid <= 1'b0;
      end else begin
         hit_valid <= tick_acc;
         if (tick_acc) begin
            hit_self  <= hs_c;
            hit_other <= ho_c;
            hit_head  <= hh_c;
         end
         if (tick_ign)
            tick_drop <= 1'b1;
         else if (clear && (state == S_IDLE))
            tick_drop <= 1'b0;
         if (clear) begin
            state <= S_CLEAR;
            row   <= '0;
            busy  <= 1'b1;
         end else if (state == S_CLEAR) begin
            if (int'(row) == GRID_H - 1) begin
               state <= S_IDLE;
               row   <= '0;
               busy  <= 1'b0;
            end else begin
               row <= row + 1'b1;
            end
         end
      end
   end

   // Map storage. Not reset directly: reset forces the sweep, which wipes
   // every row before IDLE is reached. Tail clears are issued before head
   // writes, and heads are written from the highest index down so the lowest
   // index wins on a shared cell.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         for (int c = 0; c < GRID_W; c++)
            cells[row][c] <= 3'd0;
      end else if (tick_acc) begin
         for (int k = 0; k < NSNAKE; k++) begin
            if (alive[k] && !eat[k] && t_in[k])
               cells[ty[k]][tx[k]] <= 3'd0;
         end
         for (int k = NSNAKE - 1; k >= 0; k--) begin
            if (alive[k] && h_in[k])
               cells[hy[k]][hx[k]] <= 3'(k + 1);
         end
      end
   end

`ifdef SNAKE_ARENA_LEN_EN
   logic [2:0]        h_own [NSNAKE];
   logic [2:0]        t_own [NSNAKE];
   logic [NSNAKE-1:0] len_inc;
   logic [2:0]        len_dec [NSNAKE];
   logic [11:0]       len_q [NSNAKE];

   for (genvar g = 0; g < NSNAKE; g++) begin : g_len_own
      assign h_own[g] = h_in[g] ? cells[hy[g]][hx[g]] : 3'd0;
      assign t_own[g] = t_in[g] ? cells[ty[g]][tx[g]] : 3'd0;
      assign snake_len[g*12 +: 12] = len_q[g];
   end

   // A head counts only if its write actually lands (no lower-index head on
   // the same cell) on a cell it did not already own. A tail clear counts
   // once per cell, against the cell's old owner, unless a head write gives
   // the cell straight back to that same owner.
   always_comb begin
      logic       dup;
      logic [2:0] fin;
      len_inc = '0;
      dup     = 1'b0;
      fin     = 3'd0;
      for (int k = 0; k < NSNAKE; k++)
         len_dec[k] = 3'd0;
      for (int k = 0; k < NSNAKE; k++) begin
         dup = 1'b0;
         for (int i = 0; i < k; i++) begin
            if (alive[i] && (hd[i] == hd[k])) dup = 1'b1;
         end
         if (alive[k] && h_in[k] && (h_own[k] != 3'(k + 1)) && !dup)
            len_inc[k] = 1'b1;
      end
      for (int j = 0; j < NSNAKE; j++) begin
         dup = 1'b0;
         for (int i = 0; i < j; i++) begin
            if (alive[i] && !eat[i] && (tl[i] == tl[j])) dup = 1'b1;
         end
         fin = 3'd0;
         for (int i = NSNAKE - 1; i >= 0; i--) begin
            if (alive[i] && (hd[i] == tl[j])) fin = 3'(i + 1);
         end
         if (alive[j] && !eat[j] && t_in[j] && !dup && (t_own[j] != 3'd0) && (fin != t_own[j])) begin
            for (int k = 0; k < NSNAKE; k++) begin
               if (t_own[j] == 3'(k + 1)) len_dec[k] = len_dec[k] + 3'd1;
            end
         end
      end
   end

   // Counters saturate at both ends and are wiped by any sweep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NSNAKE; k++) len_q[k] <= '0;
      end else if (state == S_CLEAR) begin
         for (int k = 0; k < NSNAKE; k++) len_q[k] <= '0;
      end else if (tick_acc) begin
         for (int k = 0; k < NSNAKE; k++) begin
            logic [12:0] s;
            s = {1'b0, len_q[k]} + {12'd0, len_inc[k]};
            if (s < {10'd0, len_dec[k]})
               len_q[k] <= '0;
            else if ((s - {10'd0, len_dec[k]}) > 13'd4095)
               len_q[k] <= 12'd4095;
            else
               len_q[k] <= 12'(s - {10'd0, len_dec[k]});
         end
      end
   end
`else
   assign snake_len = '0;
`endif

endmodule

// File: tb/tb_snake_arena_map.sv
// tb_snake_arena_map
// Directed bench for snake_arena_map on an 8x6 grid with two snakes.
// Ticks push their expected collision flags into a queue; an independent
// monitor pops and compares whenever hit_valid pulses. Map contents, busy,
// tick_drop and snake_len are compared directly at quiet points.

module tb_snake_arena_map;

   localparam int GW = 8;
   localparam int GH = 6;
   localparam int XW = 3;
   localparam int YW = 3;
   localparam int NS = 2;
   localparam int CW = XW + YW;

`ifdef SNAKE_ARENA_LEN_EN
   localparam bit LEN_ON = 1'b1;
`else
   localparam bit LEN_ON = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              clear;
   logic              tick;
   logic [NS-1:0]     alive;
   logic [NS-1:0]     eat;
   logic [NS*CW-1:0]  head_xy;
   logic [NS*CW-1:0]  tail_xy;
   logic [NS*CW-1:0]  next_xy;
   logic [XW-1:0]     q_x;
   logic [YW-1:0]     q_y;
   logic [2:0]        q_owner;
   logic              body_on;
   logic [NS-1:0]     hit_self;
   logic [NS-1:0]     hit_other;
   logic [NS-1:0]     hit_head;
   logic              hit_valid;
   logic              busy;
   logic              tick_drop;
   logic [NS*12-1:0]  snake_len;

   typedef struct packed {
      logic [1:0] s;
      logic [1:0] o;
      logic [1:0] h;
   } hit_t;

   hit_t exp_q [$];
   hit_t mon_e;
   int   tests_run    = 0;
   int   tests_failed = 0;

   snake_arena_map #(
      .GRID_W (GW),
      .GRID_H (GH),
      .XW     (XW),
      .YW     (YW),
      .NSNAKE (NS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .tick      (tick),
      .alive     (alive),
      .eat       (eat),
      .head_xy   (head_xy),
      .tail_xy   (tail_xy),
      .next_xy   (next_xy),
      .q_x       (q_x),
      .q_y       (q_y),
      .q_owner   (q_owner),
      .body_on   (body_on),
      .hit_self  (hit_self),
      .hit_other (hit_other),
      .hit_head  (hit_head),
      .hit_valid (hit_valid),
      .busy      (busy),
      .tick_drop (tick_drop),
      .snake_len (snake_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] pk(input int x, input int y);
      return {3'(x), 3'(y)};
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkCell(input int x, input int y, input int exp);
      q_x = 3'(x);
      q_y = 3'(y);
      #1;
      checkOutput($sformatf("cell(%0d,%0d)", x, y), int'(q_owner), exp);
      checkOutput($sformatf("body_on(%0d,%0d)", x, y), int'(body_on), (exp != 0) ? 1 : 0);
   endtask

   // One accepted tick followed by an idle cycle so the monitor sees the pulse.
   task automatic applyStimulus(input logic [1:0] a, input logic [1:0] e,
                                input logic [CW-1:0] h0, input logic [CW-1:0] h1,
                                input logic [CW-1:0] t0, input logic [CW-1:0] t1,
                                input logic [CW-1:0] n0, input logic [CW-1:0] n1,
                                input hit_t expv);
      alive   = a;
      eat     = e;
      head_xy = {h1, h0};
      tail_xy = {t1, t0};
      next_xy = {n1, n0};
      tick    = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk); #1;
      tick  = 1'b0;
      alive = '0;
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: every hit_valid pulse must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (hit_valid) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_hit_valid: got 1, expected 0");
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("hit_self",  int'(hit_self),  int'(mon_e.s));
               checkOutput("hit_other", int'(hit_other), int'(mon_e.o));
               checkOutput("hit_head",  int'(hit_head),  int'(mon_e.h));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; tick = 1'b0; alive = '0; eat = '0;
      head_xy = '0; tail_xy = '0; next_xy = '0; q_x = '0; q_y = '0;
      repeat (3) @(posedge clk);

      // Reset state
      @(negedge clk);
      checkOutput("reset_busy",      int'(busy),      1);
      checkOutput("reset_tick_drop", int'(tick_drop), 0);
      checkOutput("reset_hit_valid", int'(hit_valid), 0);
      checkOutput("reset_hits",      int'({hit_self, hit_other, hit_head}), 0);
      checkOutput("reset_len",       int'(snake_len), 0);

      // Release reset with a tick that must be dropped during the sweep
      @(posedge clk); #1;
      reset   = 1'b0;
      alive   = 2'b01;
      eat     = 2'b01;
      head_xy = {pk(0, 0), pk(1, 1)};
      tick    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("busy_sweep%0d", i), int'(busy), 1);
         @(posedge clk); #1;
         tick  = 1'b0;
         alive = '0;
      end
      @(negedge clk);
      checkOutput("busy_done",     int'(busy),      0);
      checkOutput("tick_drop_set", int'(tick_drop), 1);
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++)
            checkCell(x, y, 0);
      @(posedge clk); #1;

      // Growth then pop for snake 0
      applyStimulus(2'b01, 2'b01, pk(2,2), pk(0,0), pk(0,0), pk(0,0), pk(3,2), pk(0,0), '{s:2'b00, o:2'b00, h:2'b00});
      applyStimulus(2'b01, 2'b01, pk(3,2), pk(0,0), pk(0,0), pk(0,0), pk(4,2), pk(0,0), '{s:2'b00, o:2'b00, h:2'b00});
      applyStimulus(2'b01, 2'b00, pk(4,2), pk(0,0), pk(2,2), pk(0,0), pk(5,2), pk(0,0), '{s:2'b00, o:2'b00, h:2'b00});
      checkCell(3, 2, 1);
      checkCell(4, 2, 1);
      checkCell(2, 2, 0);
      checkOutput("len0_after_pop", int'(snake_len[11:0]),  LEN_ON ? 2 : 0);
      checkOutput("len1_after_pop", int'(snake_len[23:12]), 0);

      // Own occupied cell with eat=1 hits; the popping tail does not
      applyStimulus(2'b01, 2'b01, pk(4,2), pk(0,0), pk(3,2), pk(0,0), pk(3,2), pk(0,0), '{s:2'b01, o:2'b00, h:2'b00});
      applyStimulus(2'b01, 2'b00, pk(4,2), pk(0,0), pk(3,2), pk(0,0), pk(3,2), pk(0,0), '{s:2'b00, o:2'b00, h:2'b00});
      checkCell(3, 2, 0);
      checkCell(4, 2, 1);
      checkOutput("len0_after_tail", int'(snake_len[11:0]), LEN_ON ? 1 : 0);

      // Snake 1 runs into snake 0's body at (4,2)
      applyStimulus(2'b11, 2'b11, pk(5,2), pk(6,4), pk(3,2), pk(6,5), pk(6,2), pk(4,2), '{s:2'b00, o:2'b10, h:2'b00});
      checkCell(5, 2, 1);
      checkCell(6, 4, 2);
      checkOutput("len0_after_other", int'(snake_len[11:0]),  LEN_ON ? 2 : 0);
      checkOutput("len1_after_other", int'(snake_len[23:12]), LEN_ON ? 1 : 0);

      // Head-on at (5,5), then a clear one cycle later
      alive   = 2'b11;
      eat     = 2'b11;
      head_xy = {pk(6,4), pk(5,2)};
      tail_xy = {pk(6,5), pk(3,2)};
      next_xy = {pk(5,5), pk(5,5)};
      tick    = 1'b1;
      exp_q.push_back('{s:2'b00, o:2'b00, h:2'b11});
      @(posedge clk); #1;
      tick  = 1'b0;
      alive = '0;
      clear = 1'b1;
      @(negedge clk);
      checkOutput("tick_drop_before_clear", int'(tick_drop), 1);
      @(posedge clk); #1;
      clear = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("clear_busy%0d", i), int'(busy), 1);
         if (i == 0)
            checkOutput("tick_drop_cleared", int'(tick_drop), 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      checkOutput("clear_busy_done", int'(busy), 0);
      checkCell(4, 2, 0);
      checkCell(5, 2, 0);
      checkCell(6, 4, 0);
      checkOutput("len_after_clear", int'(snake_len), 0);
      checkOutput("hit_head_held",   int'(hit_head),  3);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         @(posedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
